// File: rtl/note_envelope_mixer.sv
// note_envelope_mixer: per-voice linear attack/release envelopes, saturating mono mix, audio-out handshake.
// Optional overrun counter port enabled by NOTE_ENVELOPE_MIXER_OVERRUN_CNT_EN.
module note_envelope_mixer #(
  parameter int NUM_VOICES = 6,
  parameter int GAIN_W     = 8,
  parameter int RAMP_DIV   = 196,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_VOICES-1:0]    voice_enable,
  input  logic [NUM_VOICES*32-1:0] voice_sample,
  input  logic                     audio_out_allowed,
  output logic [31:0]              left_channel_audio_out,
  output logic [31:0]              right_channel_audio_out,
  output logic                     write_audio_out
`ifdef NOTE_ENVELOPE_MIXER_OVERRUN_CNT_EN
  ,output logic [15:0]             overrun_count
`endif
);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int MW = 32 + $clog2(NUM_VOICES);
  localparam logic [GAIN_W-1:0] GMAX = '1;
  typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} env_t;
  env_t               state    [NUM_VOICES];
  env_t               state_nx [NUM_VOICES];
  logic [GAIN_W-1:0]  gain     [NUM_VOICES];
  logic [GAIN_W-1:0]  gain_nx  [NUM_VOICES];
  logic signed [31:0] prod     [NUM_VOICES];
  logic signed [31:0] prod_nx  [NUM_VOICES];
  logic [RW-1:0]      ramp_cnt;
  logic [SW-1:0]      sample_cnt;
  logic               ramp_tick, sample_tick, sample_tick_d, pending, take;
  logic [31:0]        held, sat;
  logic signed [MW-1:0] sum;
  assign ramp_tick   = ramp_cnt == RW'(RAMP_DIV - 1);
  assign sample_tick = sample_cnt == SW'(SAMPLE_DIV - 1);
  assign take        = pending & audio_out_allowed;
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_nx[i] = state[i];
      gain_nx[i]  = gain[i];
      case (state[i])
        IDLE: state_nx[i] = voice_enable[i] ? ATTACK : IDLE;
        ATTACK:
          if (!voice_enable[i]) state_nx[i] = RELEASE;
          else begin
            gain_nx[i]  = (ramp_tick && gain[i] != GMAX) ? gain[i] + 1'b1 : gain[i];
            state_nx[i] = (gain_nx[i] == GMAX) ? HOLD : ATTACK;
          end
        HOLD: begin
          gain_nx[i]  = GMAX;
          state_nx[i] = voice_enable[i] ? HOLD : RELEASE;
        end
        RELEASE:
          if (voice_enable[i]) state_nx[i] = ATTACK;
          else begin
            gain_nx[i]  = (ramp_tick && gain[i] != '0) ? gain[i] - 1'b1 : gain[i];
            state_nx[i] = (gain_nx[i] == '0) ? IDLE : RELEASE;
          end
        default: state_nx[i] = IDLE;
      endcase
    end
  end
  // Zero-extended gain keeps the product signed; the slice is a floor shift by GAIN_W.
  always_comb begin
    logic signed [32+GAIN_W:0] m;
    m = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      m          = $signed(voice_sample[32*i +: 32]) * $signed({1'b0, gain[i]});
      prod_nx[i] = 32'(m >>> GAIN_W);
    end
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + MW'(prod[i]);
    sat = (&sum[MW-1:31] | ~|sum[MW-1:31]) ? sum[31:0] : (sum[MW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state[i] <= IDLE;
        gain[i]  <= '0;
        prod[i]  <= '0;
      end
      ramp_cnt   <= '0;
      sample_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state[i] <= state_nx[i];
        gain[i]  <= gain_nx[i];
        if (sample_tick) prod[i] <= prod_nx[i];
      end
      ramp_cnt   <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      sample_cnt <= sample_tick ? '0 : sample_cnt + 1'b1;
    end
  end
  // A take and a new load on the same edge: old sample goes out, new one stays pending.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sample_tick_d           <= 1'b0;
      held                    <= '0;
      pending                 <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      sample_tick_d   <= sample_tick;
      pending         <= sample_tick_d | (pending & ~audio_out_allowed);
      write_audio_out <= take;
      if (sample_tick_d) held <= sat;
      if (take) begin
        left_channel_audio_out  <= held;
        right_channel_audio_out <= held;
      end
    end
  end
`ifdef NOTE_ENVELOPE_MIXER_OVERRUN_CNT_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) overrun_count <= '0;
    else if (sample_tick_d && pending && !audio_out_allowed && overrun_count != 16'hFFFF)
      overrun_count <= overrun_count + 1'b1;
  end
`endif
endmodule
